// File: rtl/mul_div_hilo_unit.sv
// mul_div_hilo_unit: HI/LO holding stage that sequences an external signed multiplier
// and performs signed restoring division into the same HI/LO pair.
module mul_div_hilo_unit #(
  parameter int WIDTH      = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic [WIDTH-1:0] mul_lo,
  input  logic [WIDTH-1:0] mul_hi,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic             hi_en,
  input  logic             lo_en,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  localparam int CW = $clog2(DIV_CYCLES);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] rem, quo, dvsr;
  logic [WIDTH:0] trial;
  logic [CW-1:0] cnt;
  logic sa, sb, dz, accept, last;
  always_comb begin
    accept = state == IDLE && start && !op[1];
    last = cnt == CW'(DIV_CYCLES - 1);
    trial = {rem, quo[WIDTH-1]} - {1'b0, dvsr};
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? (op[0] ? DIV : MUL) : IDLE;
      DIV:     state_nx = dz ? IDLE : last ? FIX : DIV;
      default: state_nx = IDLE;
    endcase
  end
  // quo starts as |dividend| and shifts its bits out into the remainder while quotient bits shift in
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
      hi_out <= '0;
      lo_out <= '0;
      mul_a <= '0;
      mul_b <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
      rem <= '0;
      quo <= '0;
      dvsr <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      dz <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      done <= 1'b0;
      if (!busy && hi_en) hi_out <= hi_in;
      if (!busy && lo_en) lo_out <= lo_in;
      if (accept) begin
        busy <= 1'b1;
        div_by_zero <= 1'b0;
        if (op[0]) begin
          sa <= a[WIDTH-1];
          sb <= b[WIDTH-1];
          quo <= a[WIDTH-1] ? -a : a;
          dvsr <= b[WIDTH-1] ? -b : b;
          rem <= '0;
          dz <= b == '0;
          cnt <= '0;
        end else begin
          mul_a <= a;
          mul_b <= b;
        end
      end
      if (state == MUL) begin
        hi_out <= mul_hi;
        lo_out <= mul_lo;
        done <= 1'b1;
        busy <= 1'b0;
      end
      if (state == DIV && dz) begin
        done <= 1'b1;
        busy <= 1'b0;
        div_by_zero <= 1'b1;
      end
      if (state == DIV && !dz) begin
        rem <= trial[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : trial[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
        cnt <= cnt + 1'b1;
      end
      if (state == FIX) begin
        lo_out <= (sa ^ sb) ? -quo : quo;
        hi_out <= sa ? -rem : rem;
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mul_div_hilo_unit.sv
// tb_mul_div_hilo_unit: scoreboard bench for mul_div_hilo_unit against an arithmetic
// reference model (longint multiply/divide) with a behavioural multiplier.
module tb_mul_div_hilo_unit;
  logic clock = 1'b0, clear = 1'b0, start = 1'b0, hi_en = 1'b0, lo_en = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] a = '0, b = '0, hi_in = '0, lo_in = '0;
  logic [31:0] mul_a, mul_b, mul_lo, mul_hi, hi_out, lo_out;
  logic busy, done, div_by_zero;
  logic signed [63:0] prod;

  typedef struct {logic [31:0] hi, lo; logic dbz; int at;} exp_t;
  exp_t sb_q[$];
  int vectors = 0, errors = 0, cyc = 0;
  logic [31:0] mhi = '0, mlo = '0, ma = '0, mb = '0;
  logic prev_done = 1'b0;

  mul_div_hilo_unit dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .a(a), .b(b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_lo(mul_lo), .mul_hi(mul_hi),
    .hi_in(hi_in), .lo_in(lo_in), .hi_en(hi_en), .lo_en(lo_en),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  assign prod = $signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b});
  assign {mul_hi, mul_lo} = prod;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (clear && done) begin
      exp_t e;
      chk("done_pulse_prev", 32'(prev_done), 32'd0);
      chk("busy_at_done", 32'(busy), 32'd0);
      if (sb_q.size() == 0) chk("unexpected_done", 32'(sb_q.size()), 32'd1);
      else begin
        e = sb_q.pop_front();
        chk("done_cycle", 32'(cyc), 32'(e.at));
        chk("hi", hi_out, e.hi);
        chk("lo", lo_out, e.lo);
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
      end
    end
    prev_done <= done;
  end

  task automatic direct_write(input logic he, le, input logic [31:0] h, l);
    hi_en = he; lo_en = le; hi_in = h; lo_in = l;
    @(negedge clock);
    hi_en = 1'b0; lo_en = 1'b0;
    if (he) mhi = h;
    if (le) mlo = l;
    chk("dw_hi", hi_out, mhi);
    chk("dw_lo", lo_out, mlo);
  endtask

  // called at a negedge with the unit idle; returns at the negedge where done is seen
  task automatic run(input logic [1:0] o, input logic [31:0] x, y, input int poke);
    exp_t e;
    longint sx, sy, qq, rr;
    int lat;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clock); #1;
    start = 1'b0;
    if (o[1]) begin
      chk("illegal_busy", 32'(busy), 32'd0);
      @(negedge clock);
      chk("illegal_done", 32'(done), 32'd0);
      chk("illegal_hi", hi_out, mhi);
      chk("illegal_lo", lo_out, mlo);
      return;
    end
    sx = longint'($signed(x)); sy = longint'($signed(y));
    e.dbz = 1'b0;
    if (o == 2'b00) begin
      {e.hi, e.lo} = sx * sy;
      ma = x; mb = y; lat = 1;
    end else if (y == 0) begin
      e.hi = mhi; e.lo = mlo; e.dbz = 1'b1; lat = 1;
    end else begin
      qq = sx / sy; rr = sx % sy;
      e.lo = qq[31:0]; e.hi = rr[31:0]; lat = 33;
    end
    e.at = cyc + lat;
    mhi = e.hi; mlo = e.lo;
    sb_q.push_back(e);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("done_after_start", 32'(done), 32'd0);
    chk("dbz_after_start", 32'(div_by_zero), 32'd0);
    for (int i = 1; i <= 40 && !done; i++) begin
      start = (i == poke); hi_en = (i == poke); op = 2'b00;
      a = $urandom; b = $urandom; hi_in = $urandom;
      @(negedge clock);
    end
    start = 1'b0; hi_en = 1'b0;
    if (!done) chk("done_timeout", 32'(done), 32'd1);
    chk("mul_a_hold", mul_a, ma);
    chk("mul_b_hold", mul_b, mb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mul_a", mul_a, 32'd0);
    clear = 1'b1;
    @(negedge clock);
    run(2'b00, 32'd7, 32'hFFFF_FFFD, 0);
    run(2'b01, 32'hFFFF_FFF9, 32'd2, 0);
    @(negedge clock);
    direct_write(1'b1, 1'b1, 32'h11, 32'h22);
    run(2'b01, 32'd5, 32'd0, 0);
    run(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    run(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run(2'b01, 32'd100, 32'd7, 5);
    run(2'b10, 32'd9, 32'd9, 0);
    run(2'b11, 32'd9, 32'd9, 0);
    run(2'b00, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run(2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 0);
    for (int n = 0; n < 40; n++) begin
      logic [1:0] o;
      logic [31:0] x, y;
      o = 2'($urandom_range(0, 2));
      x = $urandom;
      y = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300)));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clock);
        direct_write(1'($urandom), 1'($urandom), $urandom, $urandom);
      end
      run(o, x, y, $urandom_range(0, 1) ? int'($urandom_range(1, 30)) : 0);
    end
    @(negedge clock);
    start = 1'b1; op = 2'b01; a = 32'd100; b = 32'd7;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(posedge clock);
    #2 clear = 1'b0;
    #1;
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_hi", hi_out, 32'd0);
    chk("clr_lo", lo_out, 32'd0);
    chk("clr_mul_a", mul_a, 32'd0);
    chk("clr_mul_b", mul_b, 32'd0);
    mhi = '0; mlo = '0; ma = '0; mb = '0;
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    run(2'b00, 32'd3, 32'd4, 0);
    @(negedge clock);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/mul_div_hilo_unit.md
Name: mul_div_hilo_unit

Overview:
Sequencing and result-holding stage around the team's combinational 32x32 signed Booth multiplier. It latches operands and drives the multiplier's inputs, then captures its 64-bit product into the HI/LO register pair. It also performs 32-cycle signed restoring division into the same HI/LO pair. Sits between the ALU operand muxes (A/B buses) and the HI/LO read ports of the datapath.

Parameters:
WIDTH, 32, operand and HI/LO register width (the only supported value is 32; the multiplier is fixed at 32 bits)
DIV_CYCLES, 32, number of division iterations (must equal WIDTH)

Ports:
clock  input  1  system clock; all state updates on rising edge
clear  input  1  asynchronous, active-low reset
start  input  1  request a new operation; sampled on rising edge of clock
op  input  2  operation select: 2'b00 MUL, 2'b01 DIV, 2'b10 and 2'b11 illegal
a  input  32  multiplicand or dividend (signed)
b  input  32  multiplier or divisor (signed)
mul_a  output  32  registered operand driven to the multiplier's multiplicand input
mul_b  output  32  registered operand driven to the multiplier's multiplier input
mul_lo  input  32  product bits [31:0] from the multiplier
mul_hi  input  32  product bits [63:32] from the multiplier
hi_in  input  32  direct-write data for HI (MTHI)
lo_in  input  32  direct-write data for LO (MTLO)
hi_en  input  1  direct-write enable for HI
lo_en  input  1  direct-write enable for LO
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
div_by_zero  output  1  sticky flag: last DIV had b == 0
hi_out  output  32  HI register
lo_out  output  32  LO register

Behaviour:
- Reset: when clear is low, all of the following take their reset values immediately, regardless of clock: state = IDLE, hi_out = 0, lo_out = 0, mul_a = 0, mul_b = 0, busy = 0, done = 0, div_by_zero = 0. This applies mid-operation; a partial result is discarded.
- States: IDLE, MUL, DIV, FIX.
- IDLE with start = 1 and op legal is accepted at edge E0. On acceptance: busy <= 1, done <= 0, div_by_zero <= 0, and a and b are latched. An illegal op leaves the unit in IDLE with no state change.
- Accepted MUL: mul_a <= a and mul_b <= b at E0; go to MUL. At E1: hi_out <= mul_hi, lo_out <= mul_lo, done <= 1, busy <= 0, go to IDLE.
- Accepted DIV: latch |a| and |b| plus the sign bits; go to DIV.
  - If b == 0, then at E1: done <= 1, busy <= 0, div_by_zero <= 1, HI and LO unchanged, go to IDLE.
  - Otherwise, edges E1..E32 each perform one restoring step on an internal 33-bit remainder and 32-bit quotient. After E32, go to FIX.
  - At E33 (FIX): lo_out <= quotient, negated if the sign of a differs from the sign of b. hi_out <= remainder, negated if a < 0. Then done <= 1, busy <= 0, go to IDLE.
- Division semantics: quotient truncates toward zero; the remainder takes the sign of the dividend. The special case a = 0x80000000, b = 0xFFFFFFFF gives LO = 0x80000000, HI = 0 with no flag.
- done is high for exactly one cycle, then returns to 0. busy falls on the same edge that done rises.
- start while busy = 1 is ignored, including its operands. Back-to-back operation is allowed: start may be accepted on the edge immediately after done rises, since the unit is then in IDLE.
- Direct writes: hi_en and lo_en load hi_in and lo_in only when busy = 0 at the sampling edge. They are ignored while busy. If a direct write and an accepted start occur on the same edge, the write takes effect and is later overwritten by the operation's result. A DIV by zero does not overwrite it.
- hi_out and lo_out hold their value between operations. mul_a and mul_b hold their last MUL operands and are not changed by DIV.

Test Plan:
- MUL a = 7, b = 0xFFFFFFFD (−3), start at E0 -> at E1: busy = 0, done = 1 for one cycle, hi_out = 0xFFFFFFFF, lo_out = 0xFFFFFFEB.
- DIV a = 0xFFFFFFF9 (−7), b = 2 -> busy for 33 edges; at E33: done = 1, lo_out = 0xFFFFFFFD, hi_out = 0xFFFFFFFF, div_by_zero = 0.
- Preload HI = 0x11, LO = 0x22 via hi_en/lo_en; then DIV a = 5, b = 0 -> at E1: done = 1, div_by_zero = 1, HI = 0x11, LO = 0x22. A following MUL start clears div_by_zero.
- DIV a = 0x80000000, b = 0xFFFFFFFF -> at E33: lo_out = 0x80000000, hi_out = 0. Also DIV 100 / 7 -> LO = 14, HI = 2.
- Start DIV 100 / 7, pulse start with MUL and hi_en = 1 at E5 -> both ignored, and the DIV completes at E33 with LO = 14, HI = 2. A separate run asserts clear low at E10 -> outputs are immediately 0 and busy = 0; the next MUL 3 * 4 gives LO = 12, HI = 0 at E1.
- Illegal op 2'b10 with start = 1 -> busy and done stay 0 and HI/LO are unchanged. A MUL start on the edge right after a prior done is accepted with no gap.
